// File: rtl/seq_detector_param.sv
// Serial pattern detector with a runtime-loadable PAT_W-bit pattern, optional
// overlapping detection, a registered match pulse and a saturating match counter.
module seq_detector_param #(
  parameter int unsigned           PAT_W     = 4,
  parameter logic [PAT_W-1:0]      PAT_RESET = 4'b1011,
  parameter bit                    OVERLAP   = 1'b1,
  parameter int unsigned           CNT_W     = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_x_valid,
  input  logic             i_x_in,
  input  logic             i_clear,
  input  logic             i_pat_load,
  input  logic [PAT_W-1:0] i_pat_in,
  output logic             o_y_out,
  output logic [CNT_W-1:0] o_match_count,
  output logic             o_count_sat
);

  localparam int unsigned      FILL_W    = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  r_pat;
  logic [PAT_W-1:0]  r_hist;
  logic [FILL_W-1:0] r_fill;
  logic              r_y;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_sat;

  logic [PAT_W-1:0]  w_hist_n;
  logic [FILL_W-1:0] w_fill_n;
  logic              w_match;
  logic              w_cnt_max;

  always_comb begin
    w_hist_n  = {r_hist[PAT_W-2:0], i_x_in};
    w_fill_n  = (r_fill == FILL_FULL) ? r_fill : r_fill + FILL_W'(1);
    w_match   = (w_fill_n == FILL_FULL) && (w_hist_n == r_pat);
    w_cnt_max = &r_cnt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pat  <= PAT_RESET;
      r_hist <= '0;
      r_fill <= '0;
      r_y    <= 1'b0;
      r_cnt  <= '0;
      r_sat  <= 1'b0;
    end else if (i_pat_load) begin
      // New pattern invalidates any partial history but keeps statistics.
      r_pat  <= i_pat_in;
      r_hist <= '0;
      r_fill <= '0;
      r_y    <= 1'b0;
    end else if (i_clear) begin
      r_hist <= '0;
      r_fill <= '0;
      r_y    <= 1'b0;
      r_cnt  <= '0;
      r_sat  <= 1'b0;
    end else if (i_x_valid) begin
      r_hist <= w_hist_n;
      // Non-overlapping mode forces PAT_W fresh bits before the next match.
      r_fill <= (w_match && !OVERLAP) ? '0 : w_fill_n;
      r_y    <= w_match;
      if (w_match) begin
        if (w_cnt_max) begin
          r_sat <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end else begin
      r_y <= 1'b0;
    end
  end

  assign o_y_out       = r_y;
  assign o_match_count = r_cnt;
  assign o_count_sat   = r_sat;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench: instance A (overlapping, 8-bit counter) is table driven;
// instance B (non-overlapping, 2-bit counter) covers saturation by hand.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_v, a_x, a_clr, a_ld;
  logic [3:0] a_pat;
  logic       a_y, a_sat;
  logic [7:0] a_cnt;
  logic       b_v, b_x, b_clr, b_ld;
  logic [3:0] b_pat;
  logic       b_y, b_sat;
  logic [1:0] b_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  seq_detector_param dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_x_valid(a_v), .i_x_in(a_x),
    .i_clear(a_clr), .i_pat_load(a_ld), .i_pat_in(a_pat),
    .o_y_out(a_y), .o_match_count(a_cnt), .o_count_sat(a_sat)
  );

  seq_detector_param #(.OVERLAP(1'b0), .CNT_W(2)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_x_valid(b_v), .i_x_in(b_x),
    .i_clear(b_clr), .i_pat_load(b_ld), .i_pat_in(b_pat),
    .o_y_out(b_y), .o_match_count(b_cnt), .o_count_sat(b_sat)
  );

  typedef struct {
    logic       v, x, clr, ld;
    logic [3:0] pat;
    logic       exp_y;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic v, x, clr, ld, input logic [3:0] pat,
                              input logic ey, input logic [7:0] ec);
    vec_t t;
    t.v = v; t.x = x; t.clr = clr; t.ld = ld; t.pat = pat;
    t.exp_y = ey; t.exp_cnt = ec;
    vecs.push_back(t);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step_a(input logic v, x, clr, ld, input logic [3:0] pat);
    a_v = v; a_x = x; a_clr = clr; a_ld = ld; a_pat = pat;
    @(posedge clk); #1;
  endtask

  task automatic step_b(input logic v, x, clr);
    b_v = v; b_x = x; b_clr = clr; b_ld = 1'b0; b_pat = 4'b0000;
    @(posedge clk); #1;
  endtask

  logic [6:0] stream;
  logic [6:0] exp_ys;

  initial begin
    rst_n = 1'b0;
    a_v = 0; a_x = 0; a_clr = 0; a_ld = 0; a_pat = 0;
    b_v = 0; b_x = 0; b_clr = 0; b_ld = 0; b_pat = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.a_y", 32'(a_y), 0);
    chk("rst.a_cnt", 32'(a_cnt), 0);
    chk("rst.a_sat", 32'(a_sat), 0);
    chk("rst.b_cnt", 32'(b_cnt), 0);
    rst_n = 1'b1;

    // Overlapping stream 1011011 with default pattern: matches at bits 4 and 7
    add(1,1,0,0,0, 0,0); add(1,0,0,0,0, 0,0); add(1,1,0,0,0, 0,0); add(1,1,0,0,0, 1,1);
    add(1,0,0,0,0, 0,1); add(1,1,0,0,0, 0,1); add(1,1,0,0,0, 1,2);
    add(1,1,1,0,0, 0,0);
    // 1,0,1,1 with three idle cycles between bits; idle x_in=1 must be ignored
    add(1,1,0,0,0, 0,0);
    for (int k = 0; k < 3; k++) add(0,1,0,0,0, 0,0);
    add(1,0,0,0,0, 0,0);
    for (int k = 0; k < 3; k++) add(0,1,0,0,0, 0,0);
    add(1,1,0,0,0, 0,0);
    for (int k = 0; k < 3; k++) add(0,1,0,0,0, 0,0);
    add(1,1,0,0,0, 1,1);
    add(0,1,0,0,0, 0,1);
    // Load 1111 with a valid 1 on the same edge; six 1s give 3 back-to-back matches
    add(1,1,0,1,4'b1111, 0,1);
    add(1,1,0,0,0, 0,1); add(1,1,0,0,0, 0,1); add(1,1,0,0,0, 0,1);
    add(1,1,0,0,0, 1,2); add(1,1,0,0,0, 1,3); add(1,1,0,0,0, 1,4);
    add(0,1,0,0,0, 0,4);

    foreach (vecs[i]) begin
      step_a(vecs[i].v, vecs[i].x, vecs[i].clr, vecs[i].ld, vecs[i].pat);
      chk($sformatf("A[%0d].y", i), 32'(a_y), 32'(vecs[i].exp_y));
      chk($sformatf("A[%0d].cnt", i), 32'(a_cnt), 32'(vecs[i].exp_cnt));
    end

    // Reload 1011 (count kept), send 1,0,1, then reset mid-stream
    step_a(1,1,0,1,4'b1011);
    chk("ld.cnt_kept", 32'(a_cnt), 4);
    step_a(1,1,0,0,0); step_a(1,0,0,0,0); step_a(1,1,0,0,0);
    chk("pre_rst.y", 32'(a_y), 0);
    a_v = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_rst.cnt", 32'(a_cnt), 0);
    chk("async_rst.y", 32'(a_y), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step_a(1,1,0,0,0);
    chk("post_rst.no_match", 32'(a_y), 0);
    chk("post_rst.cnt", 32'(a_cnt), 0);
    step_a(1,0,0,0,0); step_a(1,1,0,0,0); step_a(1,1,0,0,0);
    chk("post_rst.match_y", 32'(a_y), 1);
    chk("post_rst.match_cnt", 32'(a_cnt), 1);
    step_a(0,0,0,0,0);

    // Non-overlapping: 1011011 matches only at bit 4
    stream = 7'b1011011;
    exp_ys = 7'b0001000;
    for (int k = 0; k < 7; k++) begin
      step_b(1'b1, stream[6-k], 1'b0);
      chk($sformatf("B.nov[%0d].y", k), 32'(b_y), 32'(exp_ys[6-k]));
    end
    chk("B.nov.cnt", 32'(b_cnt), 1);
    step_b(1'b1, 1'b1, 1'b1);
    chk("B.clr.cnt", 32'(b_cnt), 0);

    // Five matches into a 2-bit counter: saturates at 3, sticky flag from the 4th
    for (int m = 1; m <= 5; m++) begin
      step_b(1'b1, 1'b1, 1'b0);
      step_b(1'b1, 1'b0, 1'b0);
      step_b(1'b1, 1'b1, 1'b0);
      chk($sformatf("B.sat%0d.pre_y", m), 32'(b_y), 0);
      step_b(1'b1, 1'b1, 1'b0);
      chk($sformatf("B.sat%0d.y", m), 32'(b_y), 1);
      chk($sformatf("B.sat%0d.cnt", m), 32'(b_cnt), (m > 3) ? 3 : m);
      chk($sformatf("B.sat%0d.flag", m), 32'(b_sat), (m >= 4) ? 1 : 0);
    end
    step_b(1'b0, 1'b0, 1'b1);
    chk("B.clr2.cnt", 32'(b_cnt), 0);
    chk("B.clr2.sat", 32'(b_sat), 0);
    chk("B.clr2.y", 32'(b_y), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
